// File: rtl/hba_reg_bank_n_if.sv
// HBA bus bundle: master drives rnw/select/abus/dbus, slave returns
// dbus_slave and xferack_slave.
interface hba_reg_bank_n_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DBUS_WIDTH = 8
);
  logic                  hba_rnw;
  logic                  hba_select;
  logic [ADDR_WIDTH-1:0] hba_abus;
  logic [DBUS_WIDTH-1:0] hba_dbus;
  logic [DBUS_WIDTH-1:0] hba_dbus_slave;
  logic                  hba_xferack_slave;

  modport master (
    output hba_rnw,
    output hba_select,
    output hba_abus,
    output hba_dbus,
    input  hba_dbus_slave,
    input  hba_xferack_slave
  );

  modport slave (
    input  hba_rnw,
    input  hba_select,
    input  hba_abus,
    input  hba_dbus,
    output hba_dbus_slave,
    output hba_xferack_slave
  );
endinterface

// File: rtl/hba_reg_bank_n.sv
// HBA slave register bank: NUM_REGS registers with RO / clear-on-read
// attributes, per-register bus strobes and a parent-side write path.
// Ports: hba_clk, hba_reset (async, active high), bus (HBA slave
// modport), slv_regs (contents), slv_regs_in/slv_wr_en (parent writes),
// slv_wr_strobe/slv_rd_strobe (one-cycle pulses in the ack cycle).
module hba_reg_bank_n #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_REGS          = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] COR_MASK = '0,
  parameter logic [NUM_REGS*DBUS_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           hba_clk,
  input  logic                           hba_reset,
  hba_reg_bank_n_if.slave                bus,
  output logic [NUM_REGS*DBUS_WIDTH-1:0] slv_regs,
  input  logic [NUM_REGS*DBUS_WIDTH-1:0] slv_regs_in,
  input  logic [NUM_REGS-1:0]            slv_wr_en,
  output logic [NUM_REGS-1:0]            slv_wr_strobe,
  output logic [NUM_REGS-1:0]            slv_rd_strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    addr_hit_q;
  logic                    ack_q;
  logic [DBUS_WIDTH-1:0]   dbus_q;
  logic [NUM_REGS-1:0]     wr_stb_q;
  logic [NUM_REGS-1:0]     rd_stb_q;

  logic [DBUS_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DBUS_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                      hit;
  logic                      access;
  logic [REG_ADDR_WIDTH-1:0] off;
  logic [NUM_REGS-1:0]       rd_sel;
  logic [NUM_REGS-1:0]       wr_sel;
  logic [DBUS_WIDTH-1:0]     rd_data;

  assign hit = bus.hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH]
               == PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
  assign off    = bus.hba_abus[REG_ADDR_WIDTH-1:0];
  assign access = (state_q == ACCESS);

  // Offsets past NUM_REGS match no register: read 0, write dropped.
  always_comb begin
    rd_sel  = '0;
    wr_sel  = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(off) == 32'(i)) begin
        rd_data   = regs_q[i];
        rd_sel[i] = access & bus.hba_rnw;
        wr_sel[i] = access & ~bus.hba_rnw & ~RO_MASK[i];
      end
    end
  end

  // Bus write beats parent write beats clear-on-read.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = bus.hba_dbus;
      end else if (slv_wr_en[i]) begin
        regs_d[i] = slv_regs_in[i*DBUS_WIDTH +: DBUS_WIDTH];
      end else if (rd_sel[i] & COR_MASK[i]) begin
        regs_d[i] = '0;
      end
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUES[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q    <= IDLE;
      addr_hit_q <= 1'b0;
      ack_q      <= 1'b0;
      dbus_q     <= '0;
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
    end else begin
      // Dropping the hit on ack keeps one select from acking twice.
      addr_hit_q <= (~bus.hba_select | ack_q) ? 1'b0 : hit;
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
      unique case (state_q)
        IDLE: begin
          ack_q  <= 1'b0;
          dbus_q <= '0;
          if (addr_hit_q) begin
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          ack_q    <= 1'b1;
          dbus_q   <= bus.hba_rnw ? rd_data : '0;
          rd_stb_q <= rd_sel;
          wr_stb_q <= wr_sel;
          state_q  <= WAIT;
        end
        WAIT: begin
          ack_q   <= 1'b0;
          dbus_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          dbus_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.hba_xferack_slave = ack_q;
  assign bus.hba_dbus_slave    = dbus_q;
  assign slv_wr_strobe         = wr_stb_q;
  assign slv_rd_strobe         = rd_stb_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign slv_regs[g*DBUS_WIDTH +: DBUS_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_hba_reg_bank_n.sv
// Directed bench for hba_reg_bank_n: vector table of bus/parent
// operations plus an asynchronous reset abort sequence.
module tb_hba_reg_bank_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] slv_regs;
  logic [31:0] slv_regs_in;
  logic [3:0]  slv_wr_en;
  logic [3:0]  slv_wr_strobe;
  logic [3:0]  slv_rd_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hba_reg_bank_n_if #(.ADDR_WIDTH(12), .DBUS_WIDTH(8)) bus ();

  hba_reg_bank_n #(
    .DBUS_WIDTH       (8),
    .PERIPH_ADDR_WIDTH(4),
    .REG_ADDR_WIDTH   (8),
    .PERIPH_ADDR      (0),
    .NUM_REGS         (4),
    .RO_MASK          (4'b1000),
    .COR_MASK         (4'b0001),
    .RESET_VALUES     (32'h44332211)
  ) dut (
    .hba_clk      (clk),
    .hba_reset    (rst),
    .bus          (bus),
    .slv_regs     (slv_regs),
    .slv_regs_in  (slv_regs_in),
    .slv_wr_en    (slv_wr_en),
    .slv_wr_strobe(slv_wr_strobe),
    .slv_rd_strobe(slv_rd_strobe)
  );

  typedef struct {
    bit          is_bus;
    bit          rnw;
    logic [3:0]  pa;
    logic [7:0]  off;
    logic [7:0]  wd;
    logic [3:0]  pen;
    logic [31:0] pdat;
    bit          eack;
    logic [7:0]  edat;
    logic [3:0]  erd;
    logic [3:0]  ewr;
    logic [31:0] eregs;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input vec_t t, output bit got, output int lat,
                      output logic [7:0] d, output logic [3:0] rs,
                      output logic [3:0] ws, output logic ack_after,
                      output logic [7:0] stb_after);
    got = 1'b0;
    lat = 0;
    d   = '0;
    rs  = '0;
    ws  = '0;
    bus.hba_rnw    = t.rnw;
    bus.hba_abus   = {t.pa, t.off};
    bus.hba_dbus   = t.wd;
    bus.hba_select = 1'b1;
    for (int n = 1; n <= 8 && !got; n++) begin
      if (n == 3) begin
        slv_wr_en   = t.pen;
        slv_regs_in = t.pdat;
      end
      @(negedge clk);
      slv_wr_en = '0;
      if (bus.hba_xferack_slave === 1'b1) begin
        got = 1'b1;
        lat = n;
        d   = bus.hba_dbus_slave;
        rs  = slv_rd_strobe;
        ws  = slv_wr_strobe;
      end
    end
    bus.hba_select = 1'b0;
    @(negedge clk);
    ack_after = bus.hba_xferack_slave;
    stb_after = {slv_rd_strobe, slv_wr_strobe};
    @(negedge clk);
  endtask

  initial begin
    bit          got;
    int          lat;
    logic [7:0]  d;
    logic [3:0]  rs;
    logic [3:0]  ws;
    logic        ack_after;
    logic [7:0]  stb_after;
    int          acks;

    //       bus  rnw  pa    off    wd     pen      pdat          eack edat   erd      ewr      eregs
    tv[0]  = '{1'b1, 1'b1, 4'h0, 8'd2, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h33, 4'b0100, 4'b0000, 32'h44332211};
    tv[1]  = '{1'b1, 1'b0, 4'h0, 8'd1, 8'hA5, 4'b0000, 32'h0,        1'b1, 8'h00, 4'b0000, 4'b0010, 32'h4433A511};
    tv[2]  = '{1'b1, 1'b1, 4'h0, 8'd1, 8'h00, 4'b0000, 32'h0,        1'b1, 8'hA5, 4'b0010, 4'b0000, 32'h4433A511};
    tv[3]  = '{1'b1, 1'b0, 4'h3, 8'd1, 8'h00, 4'b0000, 32'h0,        1'b0, 8'h00, 4'b0000, 4'b0000, 32'h4433A511};
    tv[4]  = '{1'b1, 1'b0, 4'h0, 8'd3, 8'hFF, 4'b0000, 32'h0,        1'b1, 8'h00, 4'b0000, 4'b0000, 32'h4433A511};
    tv[5]  = '{1'b1, 1'b1, 4'h0, 8'd3, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h44, 4'b1000, 4'b0000, 32'h4433A511};
    tv[6]  = '{1'b1, 1'b0, 4'h0, 8'd9, 8'h77, 4'b0000, 32'h0,        1'b1, 8'h00, 4'b0000, 4'b0000, 32'h4433A511};
    tv[7]  = '{1'b1, 1'b1, 4'h0, 8'd9, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h00, 4'b0000, 4'b0000, 32'h4433A511};
    tv[8]  = '{1'b1, 1'b1, 4'h0, 8'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h11, 4'b0001, 4'b0000, 32'h4433A500};
    tv[9]  = '{1'b1, 1'b1, 4'h0, 8'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h00, 4'b0001, 4'b0000, 32'h4433A500};
    tv[10] = '{1'b0, 1'b0, 4'h0, 8'd0, 8'h00, 4'b1000, 32'h5A000000, 1'b0, 8'h00, 4'b0000, 4'b0000, 32'h5A33A500};
    tv[11] = '{1'b0, 1'b0, 4'h0, 8'd0, 8'h00, 4'b0001, 32'h0000000F, 1'b0, 8'h00, 4'b0000, 4'b0000, 32'h5A33A50F};
    tv[12] = '{1'b1, 1'b1, 4'h0, 8'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h0F, 4'b0001, 4'b0000, 32'h5A33A500};
    tv[13] = '{1'b0, 1'b0, 4'h0, 8'd0, 8'h00, 4'b0001, 32'h0000000F, 1'b0, 8'h00, 4'b0000, 4'b0000, 32'h5A33A50F};
    tv[14] = '{1'b1, 1'b1, 4'h0, 8'd0, 8'h00, 4'b0001, 32'h00000077, 1'b1, 8'h0F, 4'b0001, 4'b0000, 32'h5A33A577};
    tv[15] = '{1'b1, 1'b0, 4'h0, 8'd2, 8'h12, 4'b0100, 32'h00340000, 1'b1, 8'h00, 4'b0000, 4'b0100, 32'h5A12A577};
    tv[16] = '{1'b1, 1'b1, 4'h0, 8'd2, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h12, 4'b0100, 4'b0000, 32'h5A12A577};
    tv[17] = '{1'b1, 1'b0, 4'h0, 8'd3, 8'hFF, 4'b1000, 32'hC3000000, 1'b1, 8'h00, 4'b0000, 4'b0000, 32'hC312A577};

    rst            = 1'b1;
    bus.hba_rnw    = 1'b1;
    bus.hba_select = 1'b0;
    bus.hba_abus   = '0;
    bus.hba_dbus   = '0;
    slv_regs_in    = '0;
    slv_wr_en      = '0;
    repeat (3) @(negedge clk);
    chk("rst_regs", slv_regs, 32'h44332211);
    chk("rst_ack", {31'd0, bus.hba_xferack_slave}, 32'd0);
    chk("rst_data", {24'd0, bus.hba_dbus_slave}, 32'd0);
    chk("rst_strobes", {24'd0, slv_rd_strobe, slv_wr_strobe}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_regs", slv_regs, 32'h44332211);

    for (int i = 0; i < 18; i++) begin
      if (tv[i].is_bus) begin
        xfer(tv[i], got, lat, d, rs, ws, ack_after, stb_after);
        chk($sformatf("v%0d_ack", i), {31'd0, got}, {31'd0, tv[i].eack});
        chk($sformatf("v%0d_data", i), {24'd0, d}, {24'd0, tv[i].edat});
        chk($sformatf("v%0d_rd_strobe", i), {28'd0, rs}, {28'd0, tv[i].erd});
        chk($sformatf("v%0d_wr_strobe", i), {28'd0, ws}, {28'd0, tv[i].ewr});
        chk($sformatf("v%0d_ack_after", i), {31'd0, ack_after}, 32'd0);
        chk($sformatf("v%0d_stb_after", i), {24'd0, stb_after}, 32'd0);
        if (tv[i].eack) begin
          chk($sformatf("v%0d_latency", i), lat, 32'd3);
        end
      end else begin
        slv_wr_en   = tv[i].pen;
        slv_regs_in = tv[i].pdat;
        @(negedge clk);
        slv_wr_en   = '0;
      end
      chk($sformatf("v%0d_regs", i), slv_regs, tv[i].eregs);
    end

    // Reset asserted between edges while the FSM sits in ACCESS.
    bus.hba_rnw    = 1'b0;
    bus.hba_abus   = {4'h0, 8'd1};
    bus.hba_dbus   = 8'h99;
    bus.hba_select = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst            = 1'b1;
    bus.hba_select = 1'b0;
    #1;
    chk("arst_regs", slv_regs, 32'h44332211);
    chk("arst_ack", {31'd0, bus.hba_xferack_slave}, 32'd0);
    chk("arst_data", {24'd0, bus.hba_dbus_slave}, 32'd0);
    chk("arst_strobes", {24'd0, slv_rd_strobe, slv_wr_strobe}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.hba_xferack_slave === 1'b1) acks++;
    end
    chk("arst_no_ack", acks, 32'd0);
    chk("arst_regs_hold", slv_regs, 32'h44332211);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
